// File: rtl/fpu_test_pkg.sv
// Shared definitions for the fsub byte-stream responder.
//   resp_state_t : responder FSM states
//   REQ_BYTES    : request length in bytes (x1 then x2, MSB first)
//   RSP_BYTES    : response length in bytes (y MSB first, then status)
//   status_byte  : status layout, bit 0 = ovf, bits 7:1 reserved (zero)
//   rsp_byte     : selects response byte idx from the packed {y, status} word
package fpu_test_pkg;

  typedef enum logic [1:0] {
    RECV = 2'd0,
    EXEC = 2'd1,
    SEND = 2'd2
  } resp_state_t;

  localparam int REQ_BYTES = 8;
  localparam int RSP_BYTES = 5;

  function automatic logic [7:0] status_byte(input logic ovf);
    return {7'b0, ovf};
  endfunction

  // Byte 0 is the most significant byte of the 40-bit response word.
  function automatic logic [7:0] rsp_byte(input logic [39:0] word, input logic [2:0] idx);
    logic [39:0] shifted;
    shifted = word << (8 * idx);
    return shifted[39:32];
  endfunction

endpackage

// File: rtl/fsub.sv
// Combinational IEEE-754 single-precision subtractor, y = x1 - x2.
// Round-to-nearest-even, gradual underflow, exact zero is +0 unless both
// operands are zeros of the sign that survives the subtraction.
//   x1, x2 : operands
//   y      : difference (canonical quiet NaN 7FC00000 for invalid cases)
//   ovf    : finite operands produced a result rounded to infinity
module fsub (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        sa, sb, a_nan, b_nan, swap, big_s, sml_s, eff_sub, stk, rnd_up;
  logic [7:0]  ea, eb, be, se;
  logic [22:0] fa, fb;
  logic [23:0] big_m, sml_m;
  logic [9:0]  big_e, sml_e, d, e_norm, exp_f;
  logic [26:0] big_x, sml_x, sml_sh, al, norm;
  logic [27:0] sum;
  logic [4:0]  lz, sh;
  logic [24:0] mant_r;

  // NOTE: every variable written here gets a value on every path (defaults
  // or unconditional assignments first), so no latch is inferred.
  always_comb begin
    y   = '0;
    ovf = 1'b0;

    // Subtraction is handled as x1 + (-x2).
    sa = x1[31];
    sb = ~x2[31];
    ea = x1[30:23];
    eb = x2[30:23];
    fa = x1[22:0];
    fb = x2[22:0];
    a_nan = (ea == 8'hFF) && (fa != '0);
    b_nan = (eb == 8'hFF) && (fb != '0);

    // Order operands by magnitude so the aligned difference is never negative.
    swap  = {eb, fb} > {ea, fa};
    big_s = swap ? sb : sa;
    sml_s = swap ? sa : sb;
    be    = swap ? eb : ea;
    se    = swap ? ea : eb;
    big_m = swap ? {eb != 8'd0, fb} : {ea != 8'd0, fa};
    sml_m = swap ? {ea != 8'd0, fa} : {eb != 8'd0, fb};
    // Denormals share the exponent of the smallest normal.
    big_e = (be == 8'd0) ? 10'd1 : {2'b0, be};
    sml_e = (se == 8'd0) ? 10'd1 : {2'b0, se};
    d     = big_e - sml_e;

    // Three extra low bits: guard, round, sticky.
    big_x = {big_m, 3'b0};
    sml_x = {sml_m, 3'b0};
    if (d >= 10'd27) begin
      sml_sh = '0;
      stk    = (sml_x != '0);
    end else begin
      sml_sh = sml_x >> d;
      stk    = ((sml_sh << d) != sml_x);
    end
    al = sml_sh | {26'b0, stk};

    eff_sub = big_s ^ sml_s;
    sum = eff_sub ? ({1'b0, big_x} - {1'b0, al}) : ({1'b0, big_x} + {1'b0, al});

    lz = '0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    if (sum[27]) begin
      norm   = {sum[27:2], sum[1] | sum[0]};
      e_norm = big_e + 10'd1;
      sh     = '0;
    end else begin
      // Stop shifting at the denormal boundary (biased exponent 1).
      sh     = ({5'b0, lz} < (big_e - 10'd1)) ? lz : 5'(big_e - 10'd1);
      norm   = sum[26:0] << sh;
      e_norm = big_e - {5'b0, sh};
    end

    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[26:3]} + {24'b0, rnd_up};
    // Leading one decides the field: carry-out bumps the exponent, a missing
    // hidden bit leaves a denormal (field 0).
    exp_f  = mant_r[24] ? (e_norm + 10'd1) : (mant_r[23] ? e_norm : 10'd0);

    if ((ea == 8'hFF) || (eb == 8'hFF)) begin
      if (a_nan || b_nan || ((ea == 8'hFF) && (eb == 8'hFF) && (sa != sb))) y = QNAN;
      else if (ea == 8'hFF) y = {sa, 8'hFF, 23'b0};
      else                  y = {sb, 8'hFF, 23'b0};
    end else if (sum == '0) begin
      y = {~eff_sub & big_s, 31'b0};
    end else if (exp_f >= 10'd255) begin
      y   = {big_s, 8'hFF, 23'b0};
      ovf = 1'b1;
    end else begin
      y = {big_s, exp_f[7:0], mant_r[24] ? 23'b0 : mant_r[22:0]};
    end
  end

endmodule

// File: rtl/fsub_byte_responder.sv
// Byte-stream responder around fsub: receives x1 and x2 as eight bytes,
// big-endian, runs one fsub evaluation and returns y (four bytes, MSB first)
// followed by a status byte {7'b0, ovf}. All outputs are registered.
//   clk, rstn           : clock, asynchronous active-low reset
//   in_data/valid/ready : request byte stream (ready only while receiving)
//   out_data/valid/ready: response byte stream, held until consumed
//   err_timeout         : one-cycle pulse when a partial request is dropped
//   done_count          : completed transactions, wraps
module fsub_byte_responder
  import fpu_test_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_timeout,
  output logic [CNT_W-1:0] done_count
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  resp_state_t       state, state_next;
  logic [2:0]        rx_idx;
  logic [2:0]        tx_idx;
  logic [63:0]       opnd_sr;
  logic [39:0]       rsp_word;
  logic [IDLE_W-1:0] idle_cnt;
  logic [31:0]       fsub_y;
  logic              fsub_ovf;
  logic              accept, consume;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  fsub u_fsub (
    .x1  (opnd_sr[63:32]),
    .x2  (opnd_sr[31:0]),
    .y   (fsub_y),
    .ovf (fsub_ovf)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RECV;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RECV: if (accept && (rx_idx == 3'(REQ_BYTES - 1))) state_next = EXEC;
      EXEC: state_next = SEND;
      SEND: if (consume && (tx_idx == 3'(RSP_BYTES - 1))) state_next = RECV;
      default: state_next = RECV;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_idx      <= '0;
      tx_idx      <= '0;
      opnd_sr     <= '0;
      rsp_word    <= '0;
      idle_cnt    <= '0;
      in_ready    <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      err_timeout <= 1'b0;
      done_count  <= '0;
    end else begin
      // Registered from the next state so ready never depends on live inputs.
      in_ready    <= (state_next == RECV);
      err_timeout <= 1'b0;
      case (state)
        RECV: begin
          if (accept) begin
            opnd_sr  <= {opnd_sr[55:0], in_data};
            rx_idx   <= rx_idx + 3'd1;  // wraps to 0 after the last byte
            idle_cnt <= '0;
          end else if (rx_idx != 3'd0) begin
            if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
              rx_idx      <= '0;
              opnd_sr     <= '0;
              idle_cnt    <= '0;
              err_timeout <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        EXEC: begin
          rsp_word  <= {fsub_y, status_byte(fsub_ovf)};
          out_data  <= fsub_y[31:24];
          out_valid <= 1'b1;
          tx_idx    <= '0;
        end
        SEND: begin
          if (consume) begin
            if (tx_idx == 3'(RSP_BYTES - 1)) begin
              out_valid  <= 1'b0;
              done_count <= done_count + 1'b1;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              out_data <= rsp_byte(rsp_word, tx_idx + 3'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
